// File: rtl/maxpool_ctrl_1_pkg.sv
// Shared definitions for the 2x2 stride-2 max-pool controller on the conv1 result map.
package maxpool_ctrl_1_pkg;
  localparam int N_C        = 26;
  localparam int N_R        = 26;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 10;
  localparam int OUT_ADDR_W = 8;

  localparam int POOL_C = N_C / 2;
  localparam int POOL_R = N_R / 2;
  localparam int POOL_N = POOL_C * POOL_R;

  // Window counters only need to reach the larger of the pooled dimensions.
  localparam int CNT_W = $clog2((POOL_C > POOL_R) ? POOL_C : POOL_R);

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]         cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_LAT  = 3'd2,
    ST_OUT  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;
endpackage

// File: rtl/maxpool_ctrl_1_max4.sv
// Combinational signed maximum of the four words of a 2x2 window.
// Two-level compare tree; ties keep the lower-index word.
module maxpool_max4
  import maxpool_ctrl_1_pkg::*;
(
  input  data_t a0,
  input  data_t a1,
  input  data_t a2,
  input  data_t a3,
  output data_t y
);
  data_t m01;
  data_t m23;

  // Pairwise maxima, then the maximum of the pair winners.
  always_comb begin
    m01 = (a1 > a0) ? a1 : a0;
    m23 = (a3 > a2) ? a3 : a2;
    y   = (m23 > m01) ? m23 : m01;
  end
endmodule

// File: rtl/maxpool_ctrl_1.sv
// Max-pool controller: walks the conv1 result map in 2x2 windows, reads each
// window in one access, and streams the signed maximum per pooled position.
// Build option: define MAXPOOL_RELU_EN to clamp negative maxima to zero
// (fused ReLU); control timing is the same either way.
//
// state | meaning
// IDLE  | waiting for start
// RD    | issue window read at (2*pr, 2*pc)
// LAT   | read data valid, register pooled value and index
// OUT   | present pooled value until accepted
// FIN   | one-cycle done, counters cleared
module maxpool_ctrl_1
  import maxpool_ctrl_1_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_ren,
  output logic [ADDR_W-1:0]     mem_radd1,
  output logic [ADDR_W-1:0]     mem_radd2,
  input  logic [DATA_W-1:0]     mem_rdata0,
  input  logic [DATA_W-1:0]     mem_rdata1,
  input  logic [DATA_W-1:0]     mem_rdata2,
  input  logic [DATA_W-1:0]     mem_rdata3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0]     out_data
);
  state_t state, state_nxt;
  cnt_t   pr, pc, pr_nxt, pc_nxt;
  data_t  max_raw, max_pool;
  logic   hs, last_win;

  assign hs       = (state == ST_OUT) && out_ready;
  assign last_win = (pr == cnt_t'(POOL_R - 1)) && (pc == cnt_t'(POOL_C - 1));

  maxpool_max4 u_max4 (
    .a0 (mem_rdata0),
    .a1 (mem_rdata1),
    .a2 (mem_rdata2),
    .a3 (mem_rdata3),
    .y  (max_raw)
  );

  // Optional fused ReLU on the window maximum.
  always_comb begin
`ifdef MAXPOOL_RELU_EN
    max_pool = max_raw[DATA_W-1] ? '0 : max_raw;
`else
    max_pool = max_raw;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RD;
      ST_RD:   state_nxt = ST_LAT;
      ST_LAT:  state_nxt = ST_OUT;
      ST_OUT:  if (out_ready) state_nxt = last_win ? ST_FIN : ST_RD;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from state.
  always_comb begin
    mem_ren   = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state)
      ST_RD:   mem_ren   = 1'b1;
      ST_OUT:  out_valid = 1'b1;
      ST_FIN:  done      = 1'b1;
      default: ;
    endcase
  end

  // Window counter advance; computed ahead so the read address can be loaded
  // with the window that RD will actually fetch.
  always_comb begin
    pr_nxt = pr;
    pc_nxt = pc;
    if (hs) begin
      if (pc == cnt_t'(POOL_C - 1)) begin
        pc_nxt = '0;
        pr_nxt = (pr == cnt_t'(POOL_R - 1)) ? '0 : pr + 1'b1;
      end else begin
        pc_nxt = pc + 1'b1;
      end
    end
    if (state == ST_FIN) begin
      pr_nxt = '0;
      pc_nxt = '0;
    end
  end

  // Window counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr <= '0;
      pc <= '0;
    end else begin
      pr <= pr_nxt;
      pc <= pc_nxt;
    end
  end

  // Busy spans accepted start through the done cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            busy <= 1'b0;
    else if (state == ST_IDLE && start) busy <= 1'b1;
    else if (state == ST_FIN)           busy <= 1'b0;
  end

  // Read address loaded on entry to RD, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_radd1 <= '0;
      mem_radd2 <= '0;
    end else if (state_nxt == ST_RD) begin
      mem_radd1 <= ADDR_W'({pr_nxt, 1'b0});
      mem_radd2 <= ADDR_W'({pc_nxt, 1'b0});
    end
  end

  // Pooled result and linear index captured while read data is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_addr <= '0;
    end else if (state == ST_LAT) begin
      out_data <= max_pool;
      out_addr <= OUT_ADDR_W'(pr) * OUT_ADDR_W'(POOL_C) + OUT_ADDR_W'(pc);
    end
  end
endmodule

// File: tb/tb_maxpool_ctrl_1.sv
// Self-checking bench for maxpool_ctrl_1: window vectors, full frames,
// backpressure, start-while-busy and mid-frame reset against a reference model.
module tb_maxpool_ctrl_1;
  localparam int NR = 26, NC = 26, PR = 13, PC = 13, PN = 169;

  logic       clk = 1'b0;
  logic       rst, start, out_ready;
  logic       busy, done, mem_ren, out_valid;
  logic [9:0] mem_radd1, mem_radd2;
  logic [7:0] mem_rdata0, mem_rdata1, mem_rdata2, mem_rdata3;
  logic [7:0] out_addr, out_data;

  logic [7:0] mem [0:NR-1][0:NC-1];

  int checks = 0, errors = 0;
  int sb_idx = 0, rd_idx = 0, done_cnt = 0;
  int last_r = -1, last_c = -1;

  typedef struct {
    int a, b, c, d;
    int exp_raw;
  } vec_t;
  vec_t vecs[8];

  maxpool_ctrl_1 dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_ren(mem_ren), .mem_radd1(mem_radd1), .mem_radd2(mem_radd2),
    .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1),
    .mem_rdata2(mem_rdata2), .mem_rdata3(mem_rdata3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Conv1 buffer model: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_ren) begin
      mem_rdata0 <= mem[mem_radd1][mem_radd2];
      mem_rdata1 <= mem[mem_radd1][mem_radd2 + 1];
      mem_rdata2 <= mem[mem_radd1 + 1][mem_radd2];
      mem_rdata3 <= mem[mem_radd1 + 1][mem_radd2 + 1];
    end
  end

  function automatic int relu(input int v);
`ifdef MAXPOOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: max over the 2x2 window of pooled index k.
  function automatic int exp_val(input int k);
    int r, c, m, v;
    r = 2 * (k / PC);
    c = 2 * (k % PC);
    m = -100000;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        v = int'($signed(mem[r+i][c+j]));
        if (v > m) m = v;
      end
    return relu(m);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic fill_random();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) mem[r][c] = 8'($urandom);
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) mem[r][c] = 8'((r + c) % 100);
  endtask

  task automatic wait_out(input int a);
    int n = 0;
    while (!(out_valid && int'(out_addr) == a) && n < 3000) begin
      tick();
      n++;
    end
    chk("wait_out_bound", int'(n < 3000), 1);
  endtask

  task automatic wait_rd(input int r, input int c);
    int n = 0;
    while (!(mem_ren && int'(mem_radd1) == r && int'(mem_radd2) == c) && n < 3000) begin
      tick();
      n++;
    end
    chk("wait_rd_bound", int'(n < 3000), 1);
  endtask

  task automatic wait_done(input bit rand_ready, output int n);
    n = 1;
    while (!done && n < 6000) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("wait_done_bound", int'(n < 6000), 1);
    out_ready = 1'b1;
  endtask

  initial begin
    int n;
    vecs[0] = '{5, -3, 7, 2, 7};
    vecs[1] = '{-8, -2, -5, -128, -2};
    vecs[2] = '{-128, -128, -128, -128, -128};
    vecs[3] = '{127, -128, 0, 1, 127};
    vecs[4] = '{0, 0, 0, 0, 0};
    vecs[5] = '{-1, 3, 3, -7, 3};
    vecs[6] = '{1, 2, 3, 4, 4};
    vecs[7] = '{-5, -6, -7, -1, -1};

    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    fill_random();

    // Scoreboard: every read address and every accepted output.
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          sb_idx = 0;
          rd_idx = 0;
        end else begin
          if (done) done_cnt++;
          if (mem_ren) begin
            chk("rd_row", int'(mem_radd1), 2 * ((rd_idx % PN) / PC));
            chk("rd_col", int'(mem_radd2), 2 * ((rd_idx % PN) % PC));
            last_r = int'(mem_radd1);
            last_c = int'(mem_radd2);
            rd_idx++;
          end
          if (out_valid && out_ready) begin
            chk("sb_addr", int'(out_addr), sb_idx % PN);
            chk("sb_data", int'($signed(out_data)), exp_val(sb_idx % PN));
            sb_idx++;
          end
        end
      end
    join_none

    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ren", int'(mem_ren), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_addr", int'(out_addr), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_radd", int'({mem_radd1, mem_radd2}), 0);
    rst = 1'b0;
    tick();

    // Window vectors at (0,0), checked cycle by cycle through first output.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      fill_random();
      mem[0][0] = 8'(vecs[i].a);
      mem[0][1] = 8'(vecs[i].b);
      mem[1][0] = 8'(vecs[i].c);
      mem[1][1] = 8'(vecs[i].d);
      pulse_start();
      chk("v_ren", int'(mem_ren), 1);
      chk("v_radd", int'({mem_radd1, mem_radd2}), 0);
      chk("v_busy", int'(busy), 1);
      tick();
      chk("v_lat_ren", int'(mem_ren), 0);
      chk("v_lat_valid", int'(out_valid), 0);
      tick();
      chk("v_valid", int'(out_valid), 1);
      chk("v_addr", int'(out_addr), 0);
      chk("v_data", int'($signed(out_data)), relu(vecs[i].exp_raw));
    end

    // Full ramp frame with out_ready tied high.
    do_reset();
    fill_ramp();
    done_cnt = 0;
    pulse_start();
    wait_done(1'b0, n);
    chk("frame_cycles", n, 3 * PN + 1);
    chk("frame_count", sb_idx, PN);
    chk("frame_last_row", last_r, 24);
    chk("frame_last_col", last_c, 24);
    tick();
    chk("frame_busy_after", int'(busy), 0);
    chk("frame_done_once", done_cnt, 1);

    // Random data with random backpressure.
    do_reset();
    fill_random();
    done_cnt = 0;
    pulse_start();
    wait_done(1'b1, n);
    tick();
    chk("bp_count", sb_idx, PN);
    chk("bp_done_once", done_cnt, 1);
    chk("bp_busy_after", int'(busy), 0);

    // Stall five cycles at output 20.
    do_reset();
    fill_random();
    pulse_start();
    wait_rd(2, 14);
    out_ready = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_addr", int'(out_addr), 20);
      chk("stall_data", int'($signed(out_data)), exp_val(20));
      chk("stall_no_ren", int'(mem_ren), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("stall_valid_drop", int'(out_valid), 0);
    chk("stall_next_ren", int'(mem_ren), 1);
    tick();
    tick();
    chk("stall_next_addr", int'(out_addr), 21);
    chk("stall_next_valid", int'(out_valid), 1);
    wait_done(1'b0, n);
    chk("stall_count", sb_idx, PN);

    // Start pulsed while busy is ignored.
    do_reset();
    fill_random();
    done_cnt = 0;
    pulse_start();
    wait_out(40);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0, n);
    tick();
    chk("restart_count", sb_idx, PN);
    chk("restart_done_once", done_cnt, 1);
    chk("restart_idle", int'(busy), 0);

    // Asynchronous reset mid-frame, then a clean restart.
    do_reset();
    fill_random();
    pulse_start();
    wait_out(50);
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_addr", int'(out_addr), 0);
    chk("arst_data", int'(out_data), 0);
    chk("arst_ren", int'(mem_ren), 0);
    chk("arst_radd", int'({mem_radd1, mem_radd2}), 0);
    done_cnt = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("arst_no_done", done_cnt, 0);
    fill_random();
    pulse_start();
    chk("arst_ren2", int'(mem_ren), 1);
    chk("arst_radd2", int'({mem_radd1, mem_radd2}), 0);
    tick();
    tick();
    chk("arst_first_valid", int'(out_valid), 1);
    chk("arst_first_addr", int'(out_addr), 0);
    chk("arst_first_data", int'($signed(out_data)), exp_val(0));
    wait_done(1'b0, n);
    tick();
    chk("arst_frame_count", sb_idx, PN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/maxpool_ctrl_1.md
Name: maxpool_ctrl_1

Overview:
Downstream consumer of the first conv-result buffer. Walks the 26x26 signed 8-bit conv1 result map in non-overlapping 2x2 windows (stride 2). For each window it issues one four-word read to the buffer, selects the signed maximum, and emits one pooled value per 13x13 output position over a valid/ready stream to the next layer's input memory. One run per start pulse, then done.

Parameters:
- N_C, 26, columns of the input map; must be even.
- N_R, 26, rows of the input map; must be even.
- DATA_W, 8, width of conv result and pooled output (two's complement).
- ADDR_W, 10, width of buffer row/column address ports.
- OUT_ADDR_W, 8, width of pooled output address (must hold (N_R/2)*(N_C/2)-1 = 168).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to pool one full frame
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last output handshake
- mem_ren  out  1  read enable to the conv1 result buffer
- mem_radd1  out  ADDR_W  window top-left row (even, 0..N_R-2)
- mem_radd2  out  ADDR_W  window top-left column (even, 0..N_C-2)
- mem_rdata0..3  in  DATA_W each  window words (TL, TR, BL, BR), valid one cycle after mem_ren
- out_valid  out  1  pooled value available
- out_ready  in  1  downstream accepts when high with out_valid
- out_addr  out  OUT_ADDR_W  linear pooled index pr*(N_C/2)+pc
- out_data  out  DATA_W  pooled maximum (signed)

Behaviour:
- Reset (async, any state): all outputs 0, counters pr=pc=0, state IDLE.
- FSM states: IDLE, RD, LAT, OUT, FIN.
- IDLE: start=1 -> RD, busy<=1. start ignored in every other state.
- RD (1 cycle): mem_ren=1, mem_radd1=2*pr, mem_radd2=2*pc -> LAT. mem_ren is 0 in all other states; addresses hold their last value.
- LAT (1 cycle): buffer registers are now valid. Signed max of rdata0..3 is registered into out_data, out_addr<=pr*(N_C/2)+pc -> OUT.
- OUT: out_valid=1; out_data/out_addr stable until out_valid&out_ready.
  - On handshake, advance pc. On pc wrap (N_C/2-1 -> 0), advance pr.
  - Handshake on last window (pr=N_R/2-1, pc=N_C/2-1) -> FIN. Otherwise -> RD.
  - out_valid drops in the cycle after the handshake.
- FIN (1 cycle): done=1, busy<=0, counters cleared -> IDLE.
- Throughput: 3 cycles per output with out_ready tied high. A full frame is 169*3+1 cycles after start.
- Comparison is signed (0x80 = -128 is minimum). Ties select the lowest index word; values are equal, so this is not observable.
- Reset mid-frame aborts the run. No partial done. The next start begins at window (0,0).

Optional Feature:
- MAXPOOL_RELU_EN defined: the max result is clamped to 0 when negative before registering into out_data (fused ReLU).
- Not defined: the raw signed maximum is passed through.
- Control timing is identical in both builds.

Decomposition:
- Shared package holds:
  - localparams POOL_C=N_C/2, POOL_R=N_R/2, POOL_N=POOL_C*POOL_R.
  - FSM state encoding (3-bit).
  - the DATA_W signed type.
- One natural sub-module, maxpool_max4: combinational signed 4-input max, two-level compare tree. The ReLU clamp is applied in the parent under the macro.

Test Plan:
- Window (0,0) = {5,-3,7,2}, out_ready=1, start -> mem_ren at cycle 1 with radd1=0, radd2=0; out_valid at cycle 3 with out_addr=0, out_data=7.
- All-negative window {-8,-2,-5,-128} -> out_data=0xFE without MAXPOOL_RELU_EN; 0x00 with it.
- Full frame with mem[r*26+c]=(r+c) mod 100, out_ready=1 -> 169 outputs, out_addr 0..168 in order. Each value equals (2pr+2pc+2) mod 100, or the in-window max where the mod wraps. Last read has radd1=24, radd2=24. done pulses exactly once, one cycle after the final handshake; busy low afterwards.
- out_ready low for 5 cycles during OUT at out_addr=20 -> out_data/out_addr stable, no mem_ren asserted; the handshake on re-assertion then advances to out_addr=21.
- start pulsed again while busy at out_addr=40 -> ignored; frame completes with exactly 169 outputs.
- rst asserted at out_addr=50 -> all outputs 0 immediately (async), busy=0, no done. A new start yields first output at out_addr=0 with radd1=radd2=0.
